// File: rtl/caliptra_tlul_dev_steer.sv
// caliptra_tlul_pkg: minimal TL-UL channel types shared by the steering
// block and anything that connects to it.
//
// caliptra_tlul_dev_steer: 1:N socket steering stage.
//   clk_i         clock
//   rst_i         asynchronous reset, active-high
//   tl_h_i        host request (A channel plus d_ready)
//   tl_h_o        host response (D channel plus a_ready)
//   dev_select_i  target port for the current host A beat, valid with a_valid
//   tl_d_o        per-port device requests; index N feeds the error responder
//   tl_d_i        per-port device responses; index N comes from the error responder
//   busy_o        high while any transaction is outstanding
// A requests are steered with no added latency. Only one device may have
// transactions in flight at a time, which keeps responses in order without
// any response buffering. The number in flight is capped at MaxOut.

package caliptra_tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module caliptra_tlul_dev_steer
    import caliptra_tlul_pkg::*;
#(
    parameter int N      = 4,
    parameter int MaxOut = 4,
    parameter int SelW   = $clog2(N + 1),
    parameter int CntW   = $clog2(MaxOut + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  tl_h2d_t         tl_h_i,
    output tl_d2h_t         tl_h_o,
    input  logic [SelW-1:0] dev_select_i,
    output tl_h2d_t         tl_d_o [N+1],
    input  tl_d2h_t         tl_d_i [N+1],
    output logic            busy_o
);

    logic [CntW-1:0] cnt;
    logic [SelW-1:0] sel_q;
    logic [SelW-1:0] sel_eff;
    logic            cnt_nz;
    logic            hold;
    logic            a_ready;
    logic            a_acc;
    logic            d_acc;

    // Out-of-range selects land on the error port.
    assign sel_eff = (dev_select_i > SelW'(N)) ? SelW'(N) : dev_select_i;
    assign cnt_nz  = (cnt != '0);

    // Block a device switch while anything is in flight so responses can
    // never come back out of order; also block once the cap is reached.
    assign hold    = (cnt_nz && (sel_eff != sel_q)) || (cnt == CntW'(MaxOut));
    assign a_ready = tl_d_i[sel_eff].a_ready && !hold;
    assign a_acc   = tl_h_i.a_valid && a_ready;
    assign d_acc   = tl_d_i[sel_q].d_valid && cnt_nz && tl_h_i.d_ready;
    assign busy_o  = cnt_nz;

    always_comb begin
        for (int i = 0; i <= N; i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = tl_h_i.a_valid && (sel_eff == SelW'(i)) && !hold;
            // Responses from a port we are not waiting on are never acked.
            tl_d_o[i].d_ready = tl_h_i.d_ready && (sel_q == SelW'(i)) && cnt_nz;
        end
    end

    always_comb begin
        tl_h_o         = tl_d_i[sel_q];
        tl_h_o.d_valid = tl_d_i[sel_q].d_valid && cnt_nz;
        tl_h_o.a_ready = a_ready;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt   <= '0;
            sel_q <= '0;
        end else begin
            if (a_acc) begin
                sel_q <= sel_eff;
            end
            case ({a_acc, d_acc})
                2'b10:   cnt <= cnt + CntW'(1);
                2'b01:   cnt <= cnt - CntW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_caliptra_tlul_dev_steer.sv
module tb_caliptra_tlul_dev_steer;
    import caliptra_tlul_pkg::*;

    localparam int N      = 4;
    localparam int MAXOUT = 4;

    logic    clk;
    logic    rst;
    tl_h2d_t h_in;
    tl_d2h_t h_out;
    logic [2:0] dsel;
    tl_h2d_t d_out [N+1];
    tl_d2h_t d_in  [N+1];
    logic    busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: device index of every in-flight transaction, oldest first.
    int q[$];

    caliptra_tlul_dev_steer #(.N(N), .MaxOut(MAXOUT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tl_h_i       (h_in),
        .tl_h_o       (h_out),
        .dev_select_i (dsel),
        .tl_d_o       (d_out),
        .tl_d_i       (d_in),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_sel();
        return (int'(dsel) > N) ? N : int'(dsel);
    endfunction

    // Model-side decision: may the current host request be taken now?
    function automatic bit model_may_issue();
        if (q.size() == MAXOUT) return 1'b0;
        if (q.size() != 0 && q[$] != eff_sel()) return 1'b0;
        return 1'b1;
    endfunction

    // Compare every output against the model, advance one clock, update model.
    task automatic step(input string tag);
        int          e;
        bit          exp_ar, exp_dv;
        logic [N:0]  exp_av, got_av, exp_dr, got_dr;
        #1;
        e      = eff_sel();
        exp_ar = d_in[e].a_ready && model_may_issue();
        exp_dv = (q.size() != 0) && d_in[q[0]].d_valid;
        for (int i = 0; i <= N; i++) begin
            exp_av[i] = h_in.a_valid && (i == e) && model_may_issue();
            got_av[i] = d_out[i].a_valid;
            exp_dr[i] = h_in.d_ready && (q.size() != 0) && (q[0] == i);
            got_dr[i] = d_out[i].d_ready;
        end
        check_val({tag, ".a_ready"}, h_out.a_ready, exp_ar);
        check_val({tag, ".a_valid_vec"}, got_av, exp_av);
        check_val({tag, ".d_ready_vec"}, got_dr, exp_dr);
        check_val({tag, ".d_valid"}, h_out.d_valid, exp_dv);
        check_val({tag, ".busy"}, busy, q.size() != 0);
        check_val({tag, ".a_pass"}, {d_out[e].a_address, d_out[e].a_user},
                  {h_in.a_address, h_in.a_user});
        if (exp_dv) begin
            check_val({tag, ".d_data"}, h_out.d_data, d_in[q[0]].d_data);
            check_val({tag, ".d_meta"}, {h_out.d_error, h_out.d_user, h_out.d_source},
                      {d_in[q[0]].d_error, d_in[q[0]].d_user, d_in[q[0]].d_source});
        end
        @(posedge clk);
        if (exp_dv && h_in.d_ready) void'(q.pop_front());
        if (h_in.a_valid && exp_ar) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_all();
        h_in = '0;
        dsel = '0;
        for (int i = 0; i <= N; i++) d_in[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic host_req(input logic [2:0] sel, input logic [2:0] opc, input logic [7:0] src);
        h_in.a_valid   = 1'b1;
        h_in.a_opcode  = opc;
        h_in.a_source  = src;
        h_in.a_size    = 2'd2;
        h_in.a_address = $urandom;
        h_in.a_data    = $urandom;
        h_in.a_user    = 16'($urandom);
        dsel           = sel;
    endtask

    initial begin
        logic [N:0] av;
        rst = 1'b1;
        idle_all();
        do_reset();

        // Reset, host idle
        #1;
        for (int i = 0; i <= N; i++) av[i] = d_out[i].a_valid;
        check_val("rst.a_valid_vec", av, '0);
        check_val("rst.d_valid", h_out.d_valid, 0);
        check_val("rst.busy", busy, 0);
        @(negedge clk);

        // Get to dev 1, AccessAckData next cycle
        d_in[1].a_ready = 1'b1;
        host_req(3'd1, 3'd4, 8'h11);
        step("get");
        check_val("get.busy", busy, 1);
        h_in.a_valid     = 1'b0;
        h_in.d_ready     = 1'b1;
        d_in[1].d_valid  = 1'b1;
        d_in[1].d_opcode = 3'd1;
        d_in[1].d_data   = 32'hCAFE_0001;
        #1;
        check_val("get.d_data", h_out.d_data, 32'hCAFE_0001);
        check_val("get.d_opcode", h_out.d_opcode, 1);
        step("get_d");
        check_val("get.busy_done", busy, 0);
        idle_all();

        // Back-to-back Puts to dev 2 until the cap
        d_in[2].a_ready = 1'b1;
        for (int k = 0; k < MAXOUT; k++) begin
            host_req(3'd2, 3'd0, 8'(k));
            step("put");
        end
        #1;
        check_val("cap.a_ready", h_out.a_ready, 0);
        check_val("cap.a_valid2", d_out[2].a_valid, 0);
        d_in[2].d_valid = 1'b1;
        d_in[2].d_data  = 32'h0000_2222;
        h_in.d_ready    = 1'b1;
        step("cap_free");
        step("cap_ad_same");
        check_val("cap.depth", q.size(), MAXOUT - 1);
        h_in.a_valid = 1'b0;
        for (int k = 0; k < 8 && q.size() != 0; k++) step("cap_drain");
        check_val("cap.drained", busy, 0);
        idle_all();

        // Device switch blocked while dev 0 outstanding
        d_in[0].a_ready = 1'b1;
        d_in[3].a_ready = 1'b1;
        host_req(3'd0, 3'd1, 8'h20);
        step("sw0");
        host_req(3'd3, 3'd4, 8'h21);
        #1;
        check_val("sw.a_ready", h_out.a_ready, 0);
        check_val("sw.a_valid3", d_out[3].a_valid, 0);
        step("sw_blk");
        d_in[0].d_valid = 1'b1;
        h_in.d_ready    = 1'b1;
        step("sw_d0");
        d_in[0].d_valid = 1'b0;
        #1;
        check_val("sw.a_ready_after", h_out.a_ready, 1);
        step("sw3");
        h_in.a_valid = 1'b0;
        d_in[3].d_valid = 1'b1;
        step("sw3_d");
        idle_all();

        // Out-of-range select goes to the error port
        d_in[N].a_ready = 1'b1;
        host_req(3'd7, 3'd4, 8'h5A);
        #1;
        check_val("err.a_valid4", d_out[N].a_valid, 1);
        step("err_a");
        h_in.a_valid      = 1'b0;
        h_in.d_ready      = 1'b1;
        d_in[N].d_valid   = 1'b1;
        d_in[N].d_error   = 1'b1;
        d_in[N].d_source  = 8'h5A;
        d_in[N].d_size    = 2'd2;
        #1;
        check_val("err.d_error", h_out.d_error, 1);
        check_val("err.echo", {h_out.d_source, h_out.d_size}, {8'h5A, 2'd2});
        step("err_d");
        idle_all();

        // Reset with two outstanding, then a late response
        d_in[1].a_ready = 1'b1;
        host_req(3'd1, 3'd4, 8'h30);
        step("rm1");
        step("rm2");
        h_in.a_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        #1;
        check_val("rm.busy_async", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        d_in[1].d_valid = 1'b1;
        h_in.d_ready    = 1'b1;
        #1;
        check_val("rm.late_d_valid", h_out.d_valid, 0);
        check_val("rm.late_d_ready", d_out[1].d_ready, 0);
        step("rm_late");
        idle_all();

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            h_in.a_valid   = ($urandom_range(0, 3) != 0);
            h_in.a_opcode  = 3'($urandom);
            h_in.a_source  = 8'($urandom);
            h_in.a_address = $urandom;
            h_in.a_user    = 16'($urandom);
            h_in.d_ready   = ($urandom_range(0, 2) != 0);
            // Bias toward few devices so same-device streams and the cap get exercised.
            dsel = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
            for (int i = 0; i <= N; i++) begin
                d_in[i].a_ready  = ($urandom_range(0, 3) != 0);
                d_in[i].d_valid  = $urandom_range(0, 1) == 1;
                d_in[i].d_data   = $urandom;
                d_in[i].d_user   = 16'($urandom);
                d_in[i].d_source = 8'($urandom);
                d_in[i].d_error  = (i == N);
            end
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
